// File: rtl/packet_ctrl_fsm_pkg.sv
// Shared definitions for the packet control FSM: state encoding and the
// saturating-increment helper used by the frame counters.
package packet_ctrl_fsm_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned SAT_MAX_W = 32;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        PAYLOAD = 3'd1,
        CHECK   = 3'd2,
        DONE    = 3'd3,
        DROP    = 3'd4,
        GAP     = 3'd5
    } state_t;

    // Returns value+1, or value unchanged once it has reached all-ones at 'width' bits.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                     input int unsigned           width);
        logic [SAT_MAX_W-1:0] max_val;
        max_val = (width >= SAT_MAX_W) ? '1
                                       : ((SAT_MAX_W'(1) << width) - SAT_MAX_W'(1));
        return (value >= max_val) ? value : value + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/packet_ctrl_fsm_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment) and
// asynchronous active-high reset. W is limited to 32 bits by the helper.
module sat_counter
    import packet_ctrl_fsm_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= W'(sat_inc(SAT_MAX_W'(count), W));
        end
    end

endmodule

// File: rtl/packet_ctrl_fsm.sv
// Moore controller sequencing header, payload and optional CRC phases of a
// receive frame, with payload timeout, drop handling and saturating counters.
module packet_ctrl_fsm
    import packet_ctrl_fsm_pkg::*;
#(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1536,
    parameter bit          CRC_EN         = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             control,
    input  logic             type_length_valid,
    input  logic             header_error,
    input  logic             packet_size_valid,
    input  logic             crc_done,
    input  logic             crc_ok,
    input  logic             clear_counters,
    output logic             enable_header,
    output logic             enable_payload,
    output logic             enable_crc,
    output logic             packet_done,
    output logic             packet_drop,
    output logic [CNT_W-1:0] valid_packet_count,
    output logic [CNT_W-1:0] drop_packet_count,
    output logic [2:0]       state_o
);

    localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    state_t          state_next;
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Holds 0 outside PAYLOAD, so it reads k-1 during the k-th PAYLOAD cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state != PAYLOAD) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    always_comb begin
        state_next     = state;
        enable_header  = 1'b0;
        enable_payload = 1'b0;
        enable_crc     = 1'b0;
        packet_done    = 1'b0;
        packet_drop    = 1'b0;
        case (state)
            IDLE: begin
                enable_header = 1'b1;
                if (header_error) begin
                    state_next = DROP;
                end else if (control && type_length_valid) begin
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                enable_payload = 1'b1;
                if (packet_size_valid) begin
                    state_next = CRC_EN ? CHECK : DONE;
                end else if (!control) begin
                    state_next = DROP;
                end else if (to_cnt == TO_LAST) begin
                    state_next = DROP;
                end
            end
            CHECK: begin
                enable_crc = 1'b1;
                if (crc_done) begin
                    state_next = crc_ok ? DONE : DROP;
                end
            end
            DONE: begin
                packet_done = 1'b1;
                state_next  = GAP;
            end
            DROP: begin
                packet_drop = 1'b1;
                state_next  = GAP;
            end
            GAP: begin
                if (!control) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign state_o = state;

    sat_counter #(.W(CNT_W)) u_good_cnt (
        .clock (clock),
        .reset (reset),
        .clear (clear_counters),
        .inc   (packet_done),
        .count (valid_packet_count)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clock (clock),
        .reset (reset),
        .clear (clear_counters),
        .inc   (packet_drop),
        .count (drop_packet_count)
    );

endmodule
